obstacle_gen: RTL and testbench
===============================

OBSTACLE_GEN -- requirements
Module: obstacle_gen

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL provide `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide `frame_tick`, input, 1 bit: one-cycle pulse per video frame; all motion and flicker advance only on it.
REQ-004 SHALL provide `start`, input, 1 bit: level or pulse; begins a run from IDLE.
REQ-005 SHALL provide `game_over`, input, 1 bit: collision flag from the renderer.
REQ-006 SHALL provide `obs1_x` and `obs2_x`, output, 10 bits each: slot x-position, screen x + 100; value 0 means parked off-screen.
REQ-007 SHALL provide `obs1_type` and `obs2_type`, output, 2 bits each: 00 flat, 01 tall, 10 falling triangle, 11 rising triangle.
REQ-008 SHALL provide `obs1_pos` and `obs2_pos`, output, 2 bits each: 00 top, 01 middle, 10 bottom; never 11.
REQ-009 SHALL provide `flick1` and `flick2`, output, 1 bit each: colour-flicker phase per slot.
REQ-010 SHALL provide `score`, output, 16 bits: count of obstacles cleared.
REQ-011 SHALL provide `running`, output, 1 bit: high only in state RUN.

Function
REQ-012 SHALL implement FSM IDLE -> RUN on `start`=1; RUN -> HALT on `game_over`=1; HALT held until `reset`.
REQ-013 SHALL keep a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1), stepping every clk cycle in RUN, frozen in IDLE/HALT.
REQ-014 SHALL, on `frame_tick` in RUN, move each active slot: x <= x - speed; if x < speed+1 the slot SHALL park (x=0, inactive) and `score` SHALL increment, saturating at 16'hFFFF.
REQ-015 SHALL, on the same `frame_tick`, spawn at most one obstacle: slot 1 if inactive and (slot 2 inactive or obs2_x <= 440); else slot 2 if inactive and (slot 1 inactive or obs1_x <= 440).
REQ-016 SHALL set a spawned slot to x=740, type=lfsr[1:0], pos=lfsr[3:2] with 11 mapped to 01; type/pos SHALL stay constant while the slot is active.
REQ-017 SHALL make a slot parked in the same tick ineligible to spawn until the next tick.
REQ-018 SHALL keep a 3-bit per-slot frame counter, cleared on spawn and incremented on each `frame_tick` while active; flickN SHALL toggle when the counter wraps 7->0 and SHALL be 0 when the slot is inactive.
REQ-019 SHALL, when `game_over` and `frame_tick` occur in the same cycle in RUN, give priority to HALT: no move, spawn or score change.
REQ-020 SHALL hold all outputs frozen in HALT, so the final frame stays displayed.
REQ-021 SHALL ignore `frame_tick` and `game_over` in IDLE.

Reset
REQ-022 SHALL, on `reset`, set state IDLE, both slots inactive, all obsN_x=0, types=00, pos=00, flicks=0, score=0, running=0, LFSR=16'hACE1, speed=4, effective the next edge.
REQ-023 SHALL give `reset` asserted mid-RUN or mid-HALT full precedence over every other input.

Configuration
REQ-024 SHALL, with macro OBSTACLE_SPEED_RAMP_EN defined, keep a 4-bit spawn counter and raise speed by 1 on every 16th spawn, saturating at 8.
REQ-025 SHALL, without OBSTACLE_SPEED_RAMP_EN, hold speed constant at 4 and omit the spawn counter.

Verification
REQ-026 SHALL cover: reset, start, one frame_tick -> obs1_x=740, pos!=11, obs2_x=0, running=1.
REQ-027 SHALL cover: 80 further ticks at speed 4 -> obs1_x=420, obs2_x spawned at 740 on the tick obs1_x first <=440.
REQ-028 SHALL cover: slot at x=3, tick -> x=0, score+1, flick=0, no respawn the same tick.
REQ-029 SHALL cover: game_over coincident with frame_tick -> positions unchanged, running=0, held for 100 ticks.
REQ-030 SHALL cover: reset asserted mid-RUN -> all outputs at reset values the next cycle; LFSR restart yields an identical first type/pos.
REQ-031 SHALL cover: with OBSTACLE_SPEED_RAMP_EN, after 16 spawns the per-tick decrement is 5; without the macro it stays 4.

Source files
------------

// File: rtl/obstacle_gen.sv
// obstacle_gen: two-slot scrolling obstacle generator with LFSR-chosen type/position and score.
// Optional OBSTACLE_SPEED_RAMP_EN: speed rises by 1 every 16th spawn, saturating at 8.
`default_nettype none

module obstacle_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        game_over,
  output logic [9:0]  obs1_x,
  output logic [9:0]  obs2_x,
  output logic [1:0]  obs1_type,
  output logic [1:0]  obs2_type,
  output logic [1:0]  obs1_pos,
  output logic [1:0]  obs2_pos,
  output logic        flick1,
  output logic        flick2,
  output logic [15:0] score,
  output logic        running
);

  localparam logic [9:0]  SPAWN_X   = 10'd740;
  localparam logic [9:0]  SPAWN_GAP = 10'd440;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  state_t state, state_next;

  logic [15:0] lfsr;
  logic [2:0]  cnt1, cnt2;
  logic [3:0]  speed;
  logic        tick_run;
  logic        park1, park2, spawn1, spawn2;
  logic [9:0]  x1_mv, x2_mv;
  logic [1:0]  pos_new;
  logic [16:0] score_sum;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (game_over) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign running  = (state == RUN);
  assign tick_run = running && frame_tick && !game_over;

  // A slot is active exactly when its x is nonzero; parking happens before x could reach 0.
  always_comb begin
    park1  = (obs1_x != 10'd0) && (obs1_x < ({6'd0, speed} + 10'd1));
    park2  = (obs2_x != 10'd0) && (obs2_x < ({6'd0, speed} + 10'd1));
    x1_mv  = (park1 || obs1_x == 10'd0) ? 10'd0 : obs1_x - {6'd0, speed};
    x2_mv  = (park2 || obs2_x == 10'd0) ? 10'd0 : obs2_x - {6'd0, speed};
    // Eligibility uses the pre-tick x, so a slot parked on this tick cannot respawn yet.
    spawn1 = (obs1_x == 10'd0) && ((x2_mv == 10'd0) || (x2_mv <= SPAWN_GAP));
    spawn2 = !spawn1 && (obs2_x == 10'd0) && ((x1_mv == 10'd0) || (x1_mv <= SPAWN_GAP));
    pos_new   = (lfsr[3:2] == 2'b11) ? 2'b01 : lfsr[3:2];
    score_sum = {1'b0, score} + {15'd0, park1} + {15'd0, park2};
  end

  always_ff @(posedge clk) begin
    if (reset)        lfsr <= LFSR_SEED;
    else if (running) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      obs1_x <= '0; obs2_x <= '0;
      obs1_type <= '0; obs2_type <= '0;
      obs1_pos <= '0; obs2_pos <= '0;
      cnt1 <= '0; cnt2 <= '0;
      flick1 <= 1'b0; flick2 <= 1'b0;
      score <= '0;
    end else if (tick_run) begin
      obs1_x <= x1_mv;
      obs2_x <= x2_mv;
      score  <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      if (spawn1) begin
        obs1_x <= SPAWN_X; obs1_type <= lfsr[1:0]; obs1_pos <= pos_new;
        cnt1 <= '0; flick1 <= 1'b0;
      end else if (park1) begin
        cnt1 <= '0; flick1 <= 1'b0;
      end else if (obs1_x != 10'd0) begin
        cnt1 <= cnt1 + 3'd1;
        if (cnt1 == 3'd7) flick1 <= ~flick1;
      end
      if (spawn2) begin
        obs2_x <= SPAWN_X; obs2_type <= lfsr[1:0]; obs2_pos <= pos_new;
        cnt2 <= '0; flick2 <= 1'b0;
      end else if (park2) begin
        cnt2 <= '0; flick2 <= 1'b0;
      end else if (obs2_x != 10'd0) begin
        cnt2 <= cnt2 + 3'd1;
        if (cnt2 == 3'd7) flick2 <= ~flick2;
      end
    end
  end

`ifdef OBSTACLE_SPEED_RAMP_EN
  logic [3:0] spawn_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      spawn_cnt <= '0;
      speed     <= 4'd4;
    end else if (tick_run && (spawn1 || spawn2)) begin
      spawn_cnt <= spawn_cnt + 4'd1;
      if (spawn_cnt == 4'd15 && speed < 4'd8) speed <= speed + 4'd1;
    end
  end
`else
  assign speed = 4'd4;
`endif

endmodule

`default_nettype wire

// File: tb/tb_obstacle_gen.sv
// Directed self-checking bench for obstacle_gen.
`default_nettype none

module tb_obstacle_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic [9:0]  obs1_x, obs2_x;
  logic [1:0]  obs1_type, obs2_type, obs1_pos, obs2_pos;
  logic        flick1, flick2, running;
  logic [15:0] score;

  int tests_run = 0;
  int tests_failed = 0;

  obstacle_gen dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .game_over(game_over),
    .obs1_x(obs1_x), .obs2_x(obs2_x), .obs1_type(obs1_type), .obs2_type(obs2_type),
    .obs1_pos(obs1_pos), .obs2_pos(obs2_pos), .flick1(flick1), .flick2(flick2),
    .score(score), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".x"}, {obs1_x, obs2_x}, 0);
    check({tag, ".type_pos"}, {obs1_type, obs2_type, obs1_pos, obs2_pos}, 0);
    check({tag, ".flick_run"}, {flick1, flick2, running}, 0);
    check({tag, ".score"}, score, 0);
  endtask

  int spawns, n, last_slot, exp_speed;
  logic [9:0] prev1, prev2;

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");

    // IDLE ignores frame_tick and game_over
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("idle_x", obs1_x, 0);
    check("idle_run", running, 0);

    do_start();
    check("start_run", running, 1);
    tick();
    check("spawn1_x", obs1_x, 740);
    check("spawn1_type", obs1_type, 1);   // seed ACE1: bits[1:0]=01
    check("spawn1_pos", obs1_pos, 0);     // bits[3:2]=00
    check("spawn1_x2", obs2_x, 0);

    ticks(8);
    check("mv8_x", obs1_x, 708);
    check("flick_wrap", flick1, 1);
    ticks(66);
    check("mv74_x1", obs1_x, 444);
    check("mv74_x2", obs2_x, 0);
    tick();
    check("gap_x1", obs1_x, 440);
    check("gap_x2", obs2_x, 740);
    ticks(5);
    check("mv80_x1", obs1_x, 420);
    check("mv80_x2", obs2_x, 720);
    check("mv80_flick", flick1, 0);
    check("mv80_score", score, 0);

    ticks(104);
    check("edge_x1", obs1_x, 4);
    check("edge_x2", obs2_x, 304);
    tick();
    check("park_x1", obs1_x, 0);
    check("park_score", score, 1);
    check("park_flick", flick1, 0);
    check("park_x2", obs2_x, 300);
    tick();
    check("respawn_x1", obs1_x, 740);
    check("respawn_x2", obs2_x, 296);

    // game_over coincident with frame_tick
    frame_tick = 1'b1;
    game_over = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    game_over = 1'b0;
    check("halt_x", {obs1_x, obs2_x}, {10'd740, 10'd296});
    check("halt_run", running, 0);
    check("halt_score", score, 1);
    do_start();
    ticks(100);
    check("held_x", {obs1_x, obs2_x}, {10'd740, 10'd296});
    check("held_run", running, 0);
    check("held_score", score, 1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst_halt");
    do_start();
    tick();
    check("restart_type", obs1_type, 1);
    check("restart_pos", obs1_pos, 0);
    ticks(3);

    // reset mid-RUN wins over a coincident frame_tick
    reset = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    check_reset_vals("rst_run");

    do_start();
    tick();
    check("again_type", obs1_type, 1);
    check("again_pos", obs1_pos, 0);
    spawns = 1;
    last_slot = 1;
    prev1 = obs1_x;
    prev2 = obs2_x;
    n = 0;
    while (spawns < 16 && n < 4000) begin
      tick();
      n++;
      if (obs1_x == 10'd740 && prev1 != 10'd740) begin
        spawns++; last_slot = 1;
        check("pos1_legal", (obs1_pos == 2'b11), 0);
      end
      if (obs2_x == 10'd740 && prev2 != 10'd740) begin
        spawns++; last_slot = 2;
        check("pos2_legal", (obs2_pos == 2'b11), 0);
      end
      prev1 = obs1_x;
      prev2 = obs2_x;
    end
    check("spawn_budget", spawns, 16);
`ifdef OBSTACLE_SPEED_RAMP_EN
    exp_speed = 5;
`else
    exp_speed = 4;
`endif
    tick();
    check("speed_after16", 740 - ((last_slot == 1) ? int'(obs1_x) : int'(obs2_x)), exp_speed);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
